// File: rtl/als_pkg.sv
// Shared constants for the PmodALS light-sensor datapath.
// Sample width is common to the SPI interface and the averaging filter.
package als_pkg;

    localparam int ALS_DATA_W       = 8;
    localparam int ALS_AVG_LOG2_WIN = 3;

    // Filter state encoding
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/als_sample_ring.sv
// Ring buffer holding the last 2^LOG2_WIN light samples.
// o_oldest shows the entry that the next write will overwrite.
module als_sample_ring #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_oldest
);

    localparam int N = 1 << LOG2_WIN;

    logic [N-1:0][DATA_W-1:0] r_ring;
    logic [LOG2_WIN-1:0]      r_wr_ptr;

    // Pointer is exactly LOG2_WIN bits, so it wraps from N-1 to 0 on its own
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_ring   <= '0;
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_ring[r_wr_ptr] <= i_wr_data;
            r_wr_ptr         <= r_wr_ptr + LOG2_WIN'(1);
        end
    end

    assign o_oldest = r_ring[r_wr_ptr];

endmodule

// File: rtl/als_moving_avg.sv
// Boxcar moving-average filter for PmodALS samples: running sum over the
// last 2^LOG2_WIN samples, rounded mean emitted per sample once filled.
module als_moving_avg
    import als_pkg::*;
#(
    parameter int DATA_W   = ALS_DATA_W,
    parameter int LOG2_WIN = ALS_AVG_LOG2_WIN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    output logic              filled
);

    localparam int N     = 1 << LOG2_WIN;
    localparam int SUM_W = DATA_W + LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (LOG2_WIN - 1);

    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_fill_cnt;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_avg_data;
    logic              r_avg_valid;
    logic              r_filled;

    logic              w_accept;
    logic [DATA_W-1:0] w_oldest;
    logic [DATA_W-1:0] w_sub;
    logic [SUM_W-1:0]  w_sum_next;
    logic [SUM_W-1:0]  w_sum_rnd;
    logic [DATA_W-1:0] w_avg;
    logic              w_last_fill;

    assign w_accept = in_valid & ~clear;

    als_sample_ring #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (clear),
        .i_wr_en   (w_accept),
        .i_wr_data (in_data),
        .o_oldest  (w_oldest)
    );

    // Nothing has been evicted yet while filling, so subtract zero
    assign w_sub       = (r_state == RUN) ? w_oldest : '0;
    assign w_sum_next  = r_sum + SUM_W'(in_data) - SUM_W'(w_sub);
    // N*(2^DATA_W-1) + N/2 still fits in SUM_W bits
    assign w_sum_rnd   = w_sum_next + HALF;
    assign w_avg       = DATA_W'(w_sum_rnd >> LOG2_WIN);
    assign w_last_fill = (r_fill_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_state     <= FILL;
            r_avg_data  <= '0;
            r_avg_valid <= 1'b0;
            r_filled    <= 1'b0;
        end else if (clear) begin
            // avg_data deliberately holds so downstream display keeps its reading
            r_sum       <= '0;
            r_fill_cnt  <= '0;
            r_state     <= FILL;
            r_avg_valid <= 1'b0;
            r_filled    <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (in_valid) begin
                r_sum <= w_sum_next;
                if (r_state == FILL) begin
                    r_fill_cnt <= r_fill_cnt + CNT_W'(1);
                    if (w_last_fill) begin
                        r_state     <= RUN;
                        r_filled    <= 1'b1;
                        r_avg_valid <= 1'b1;
                        r_avg_data  <= w_avg;
                    end
                end else begin
                    r_avg_valid <= 1'b1;
                    r_avg_data  <= w_avg;
                end
            end
        end
    end

    assign avg_data  = r_avg_data;
    assign avg_valid = r_avg_valid;
    assign filled    = r_filled;

endmodule

// File: tb/tb_als_moving_avg.sv
// Directed self-checking bench for als_moving_avg (N=8, 8-bit samples).
module tb_als_moving_avg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       clear;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       filled;

    int checks   = 0;
    int failures = 0;
    int vcnt;

    always #5 clk = ~clk;

    als_moving_avg #(
        .DATA_W   (8),
        .LOG2_WIN (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clear     (clear),
        .avg_data  (avg_data),
        .avg_valid (avg_valid),
        .filled    (filled)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one cycle; returns at the negedge after the accepting edge
    task automatic send(input int d);
        in_valid = 1'b1;
        in_data  = d[7:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_avg_data", 32'(avg_data), 0);
        chk("reset_avg_valid", 32'(avg_valid), 0);
        chk("reset_filled", 32'(filled), 0);
        reset_n = 1'b1;

        // Constant fill
        for (int i = 0; i < 7; i++) begin
            send(100);
            chk("fill_no_valid", 32'(avg_valid), 0);
        end
        send(100);
        chk("fill8_valid", 32'(avg_valid), 1);
        chk("fill8_data", 32'(avg_data), 100);
        chk("fill8_filled", 32'(filled), 1);
        idle(1);
        chk("pulse_one_cycle", 32'(avg_valid), 0);
        chk("idle_hold_data", 32'(avg_data), 100);

        // Steady-state update
        send(200);
        chk("steady_valid", 32'(avg_valid), 1);
        chk("steady_avg_113", 32'(avg_data), 113);
        repeat (7) send(200);
        chk("steady_avg_200", 32'(avg_data), 200);

        // Rounding and pointer wrap
        for (int i = 0; i < 8; i++) send(i);
        chk("wrap_avg_4", 32'(avg_data), 4);
        for (int i = 8; i < 16; i++) send(i);
        chk("wrap_avg_12", 32'(avg_data), 12);
        idle(1);

        // Clear from RUN; avg_data holds
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_filled", 32'(filled), 0);
        chk("clear_valid", 32'(avg_valid), 0);
        chk("clear_hold_data", 32'(avg_data), 12);

        // Full scale, back-to-back
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            send(255);
            if (avg_valid) vcnt++;
            chk("fs_valid", 32'(avg_valid), (i >= 7) ? 1 : 0);
        end
        chk("fs_valid_count", 32'(vcnt), 9);
        chk("fs_data_255", 32'(avg_data), 255);
        idle(1);

        // Clear mid-fill with a simultaneous sample
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (5) send(50);
        in_valid = 1'b1;
        in_data  = 8'd99;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("cmf_filled", 32'(filled), 0);
        chk("cmf_valid", 32'(avg_valid), 0);
        chk("cmf_hold_data", 32'(avg_data), 255);
        for (int i = 0; i < 8; i++) begin
            send(10);
            chk("cmf_fill_valid", 32'(avg_valid), (i == 7) ? 1 : 0);
        end
        chk("cmf_avg_10", 32'(avg_data), 10);
        chk("cmf_refilled", 32'(filled), 1);

        // Reset mid-run with a sample present
        in_valid = 1'b1;
        in_data  = 8'd77;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("rst_avg_data", 32'(avg_data), 0);
        chk("rst_avg_valid", 32'(avg_valid), 0);
        chk("rst_filled", 32'(filled), 0);
        for (int i = 0; i < 8; i++) begin
            send(30);
            chk("rst_fill_valid", 32'(avg_valid), (i == 7) ? 1 : 0);
        end
        chk("rst_avg_30", 32'(avg_data), 30);

        // in_data must be ignored while in_valid is low
        in_valid = 1'b0;
        in_data  = 8'd255;
        repeat (3) @(negedge clk);
        chk("idle_no_valid", 32'(avg_valid), 0);
        send(30);
        chk("idle_data_ignored", 32'(avg_data), 30);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
